fc_layer_driver: RTL and testbench

- Sequential front/back end for a combinational fully-connected `layer` neuron.
- Accepts a serial stream of WIDTH-bit activations and assembles the parallel vector x[0:IN-1] that the layer reads.
- Holds x stable for a programmable settle time while the multiplier/adder tree/ReLU resolves, then samples z and returns it on a valid/ready result port.
- Sits between the previous layer's activation stream and one `layer` instance.

---
 rtl/fc_layer_driver.sv | 156 +++++++++++++++
 tb/tb_fc_layer_driver.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fc_layer_driver.sv
// fc_layer_driver
// Sequential wrapper around a combinational fully-connected layer. It collects
// a serial activation stream into the parallel vector x. It then holds x stable
// for SETTLE cycles while the layer resolves, samples z, and presents the
// result on a valid/ready port.
//
// Ports
//   clk, rst          clock, asynchronous active-high reset
//   s_valid/s_ready   input beat handshake; s_data activation, s_last end of vector
//   x[0:IN-1]         vector driven to the attached layer
//   z                 layer result (unsigned, already ReLU'd)
//   m_valid/m_ready   result handshake; m_data registered copy of z
//   err_len           one-cycle pulse when a vector is shorter or longer than IN
//
// Optional feature: define FC_DRIVER_DOUBLE_BUFFER_EN for two x banks. With it,
// the next vector fills while the current one settles and is handed off.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// ST_FILL   | no result in flight; accepting beats (or swapping in a full bank)
// ST_SETTLE | x frozen, settle timer counting down to the z sample
// ST_OUT    | m_data valid, waiting for m_ready
module fc_layer_driver #(
  parameter int WIDTH  = 8,
  parameter int IN     = 128,
  parameter int ZW     = WIDTH*2+$clog2(IN),
  parameter int SETTLE = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [WIDTH-1:0] s_data,
  input  logic             s_last,
  output logic [WIDTH-1:0] x [0:IN-1],
  input  logic [ZW-1:0]    z,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [ZW-1:0]    m_data,
  output logic             err_len
);

  localparam int IW = (IN > 1) ? $clog2(IN) : 1;
  localparam int CW = 8;
  localparam logic [IW-1:0] IDX_LAST = IW'(IN-1);

  typedef enum logic [1:0] {ST_FILL, ST_SETTLE, ST_OUT} state_t;

  state_t        state, state_nxt;
  logic [IW-1:0] idx;
  logic [CW-1:0] cnt;
  logic          beat, at_last, fill_done, start, capture;

  assign beat      = s_valid && s_ready;
  assign at_last   = (idx == IDX_LAST);
  assign fill_done = beat && (s_last || at_last);
  // m_valid is a state decode so that reset drops it without waiting for a clock.
  assign m_valid   = (state == ST_OUT);

`ifdef FC_DRIVER_DOUBLE_BUFFER_EN
  logic             act;
  logic             fill_full;
  logic [WIDTH-1:0] bank0 [0:IN-1];
  logic [WIDTH-1:0] bank1 [0:IN-1];

  // The fill bank is always the one not driving x.
  assign s_ready = !fill_full;
  assign start   = (state == ST_FILL) && (fill_done || fill_full);

  always_comb begin
    for (int i = 0; i < IN; i++) x[i] = act ? bank1[i] : bank0[i];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      act       <= 1'b0;
      fill_full <= 1'b0;
    end else if (start) begin
      act       <= ~act;
      fill_full <= 1'b0;
    end else if (fill_done) begin
      fill_full <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < IN; i++) begin
        bank0[i] <= '0;
        bank1[i] <= '0;
      end
    end else if (beat) begin
      for (int i = 0; i < IN; i++) begin
        if (i == int'(idx)) begin
          if (act) bank0[i] <= s_data;
          else     bank1[i] <= s_data;
        end else if (s_last && i > int'(idx)) begin
          if (act) bank0[i] <= '0;
          else     bank1[i] <= '0;
        end
      end
    end
  end
`else
  assign s_ready = (state == ST_FILL);
  assign start   = fill_done;

  // A short vector zero-fills the tail on the same edge as its last beat.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < IN; i++) x[i] <= '0;
    end else if (beat) begin
      for (int i = 0; i < IN; i++) begin
        if (i == int'(idx))                    x[i] <= s_data;
        else if (s_last && i > int'(idx))      x[i] <= '0;
      end
    end
  end
`endif

  always_comb begin
    state_nxt = state;
    capture   = 1'b0;
    case (state)
      ST_FILL:   if (start) state_nxt = ST_SETTLE;
      ST_SETTLE: if (cnt == '0) begin
                   state_nxt = ST_OUT;
                   capture   = 1'b1;
                 end
      ST_OUT:    if (m_ready) state_nxt = ST_FILL;
      default:   state_nxt = ST_FILL;
    endcase
  end

  // The settle timer is loaded with SETTLE-1 as the vector completes. The z
  // sample happens on the edge that sees it at zero, SETTLE edges after the
  // edge that took the final beat.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= ST_FILL;
      idx     <= '0;
      cnt     <= '0;
      m_data  <= '0;
      err_len <= 1'b0;
    end else begin
      state   <= state_nxt;
      err_len <= fill_done && (s_last != at_last);
      if (fill_done)  idx <= '0;
      else if (beat)  idx <= idx + IW'(1);
      if (start)             cnt <= CW'(SETTLE-1);
      else if (cnt != '0)    cnt <= cnt - CW'(1);
      if (capture) m_data <= z;
    end
  end

endmodule

// File: tb/tb_fc_layer_driver.sv
module tb_fc_layer_driver;

  logic        clk = 1'b0;
  logic        rst;
  logic        s_valid, s_ready, s_last;
  logic [7:0]  s_data;
  logic [7:0]  x [0:127];
  logic [22:0] z;
  logic        m_valid, m_ready;
  logic [22:0] m_data;
  logic        err_len;

  int tests  = 0;
  int failed = 0;

  fc_layer_driver #(.WIDTH(8), .IN(128), .ZW(23), .SETTLE(4)) dut (
    .clk(clk), .rst(rst),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_last(s_last),
    .x(x), .z(z),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
    .err_len(err_len)
  );

  always #5 clk = ~clk;

  // Model layer: z = sum of x
  always_comb begin
    z = '0;
    for (int i = 0; i < 128; i++) z = z + {15'b0, x[i]};
  end

  // Negedge monitor: records handoffs and error pulses
  int          cyc = 0, hi_cnt = 0, err_cnt = 0, err_cyc = 0;
  logic [22:0] res_q [$];
  int          res_cyc [$];
  always @(negedge clk) begin
    cyc++;
    if (m_valid) hi_cnt++;
    if (err_len) begin err_cnt++; err_cyc = cyc; end
    if (m_valid && m_ready) begin
      res_q.push_back(m_data);
      res_cyc.push_back(cyc);
    end
  end

  logic [7:0] vec [0:139];

  task automatic stream(input int first, input int n, input bit last_on_final, output int lc);
    for (int b = 0; b < n; b++) begin
      int w = 0;
      s_valid = 1'b1;
      s_data  = vec[first+b];
      s_last  = last_on_final && (b == n-1);
      while (!s_ready && w < 300) begin @(posedge clk); #1; w++; end
      if (w >= 300) begin
        tests++; failed++;
        $display("FAIL stream_stall: beat %0d never accepted, s_ready=%0b required 1", first+b, s_ready);
        break;
      end
      @(posedge clk); #1;
    end
    lc = cyc;
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  task automatic wait_results(input int n);
    int w = 0;
    while (res_q.size() < n && w < 300) begin @(posedge clk); #1; w++; end
  endtask

  task automatic wait_valid();
    int w = 0;
    while (!m_valid && w < 300) begin @(posedge clk); #1; w++; end
  endtask

  task automatic clear_results();
    res_q.delete();
    res_cyc.delete();
  endtask

  task automatic test_reset();
    rst = 1'b1; s_valid = 1'b0; s_last = 1'b0; s_data = '0; m_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    tests++; if (s_ready !== 1'b1) begin failed++; $display("FAIL reset_s_ready: got %0b expected 1", s_ready); end
    tests++; if (m_valid !== 1'b0) begin failed++; $display("FAIL reset_m_valid: got %0b expected 0", m_valid); end
    tests++; if (m_data !== 23'd0) begin failed++; $display("FAIL reset_m_data: got %0d expected 0", m_data); end
    tests++; if (err_len !== 1'b0) begin failed++; $display("FAIL reset_err_len: got %0b expected 0", err_len); end
    tests++; if (x[0] !== 8'd0 || x[127] !== 8'd0) begin failed++; $display("FAIL reset_x: got x0=%0d x127=%0d expected 0", x[0], x[127]); end
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_base();
    int lc, h0, e0;
    for (int i = 0; i < 128; i++) vec[i] = 8'(i+1);
    m_ready = 1'b1;
    clear_results();
    h0 = hi_cnt; e0 = err_cnt;
    stream(0, 128, 1'b1, lc);
    wait_results(1);
    repeat (3) @(posedge clk);
    #1;
    tests++; if (res_q.size() != 1) begin failed++; $display("FAIL base_count: got %0d results expected 1", res_q.size()); end
    if (res_q.size() >= 1) begin
      tests++; if (res_q[0] !== 23'd8256) begin failed++; $display("FAIL base_data: got %0d expected 8256", res_q[0]); end
      tests++; if (res_cyc[0] - lc != 5) begin failed++; $display("FAIL base_latency: got %0d expected 5 (negedges after last beat)", res_cyc[0] - lc); end
    end
    tests++; if (hi_cnt - h0 != 1) begin failed++; $display("FAIL base_valid_width: got %0d cycles expected 1", hi_cnt - h0); end
    tests++; if (err_cnt != e0) begin failed++; $display("FAIL base_err_len: got %0d pulses expected 0", err_cnt - e0); end
  endtask

  task automatic test_backpressure();
    int lc, bad;
    for (int i = 0; i < 128; i++) vec[i] = 8'd3;
    m_ready = 1'b0;
    clear_results();
    stream(0, 128, 1'b1, lc);
    wait_valid();
    tests++; if (m_valid !== 1'b1) begin failed++; $display("FAIL bp_valid_rise: got %0b expected 1", m_valid); end
    bad = 0;
    s_valid = 1'b1; s_data = 8'hAA; s_last = 1'b1;
    for (int k = 0; k < 20; k++) begin
      if (m_valid !== 1'b1 || m_data !== 23'd384 || s_ready !== 1'b0) bad++;
      @(posedge clk); #1;
    end
    tests++; if (bad != 0) begin failed++; $display("FAIL bp_stable: got %0d unstable cycles expected 0", bad); end
    s_valid = 1'b0; s_last = 1'b0;
    m_ready = 1'b1;
    @(posedge clk); #1;
    tests++; if (m_valid !== 1'b0) begin failed++; $display("FAIL bp_valid_drop: got %0b expected 0", m_valid); end
    tests++; if (s_ready !== 1'b1) begin failed++; $display("FAIL bp_s_ready: got %0b expected 1", s_ready); end
    repeat (2) @(posedge clk);
    #1;
    tests++; if (res_q.size() != 1) begin failed++; $display("FAIL bp_handoffs: got %0d expected 1", res_q.size()); end
    if (res_q.size() >= 1) begin
      tests++; if (res_q[0] !== 23'd384) begin failed++; $display("FAIL bp_data: got %0d expected 384", res_q[0]); end
    end
    tests++; if (x[0] !== 8'd3 || x[127] !== 8'd3) begin failed++; $display("FAIL bp_ignored_beats: got x0=%0d x127=%0d expected 3", x[0], x[127]); end
  endtask

  task automatic test_short();
    int lc, e0, bad_hi, bad_lo;
    for (int i = 0; i < 10; i++) vec[i] = 8'd5;
    m_ready = 1'b1;
    clear_results();
    e0 = err_cnt;
    stream(0, 10, 1'b1, lc);
    wait_results(1);
    repeat (2) @(posedge clk);
    #1;
    tests++; if (err_cnt - e0 != 1) begin failed++; $display("FAIL short_err_len: got %0d pulses expected 1", err_cnt - e0); end
    tests++; if (res_q.size() != 1) begin failed++; $display("FAIL short_count: got %0d expected 1", res_q.size()); end
    if (res_q.size() >= 1) begin
      tests++; if (res_q[0] !== 23'd50) begin failed++; $display("FAIL short_data: got %0d expected 50", res_q[0]); end
    end
    bad_hi = 0; bad_lo = 0;
    for (int i = 0; i < 10; i++)   if (x[i] !== 8'd5) bad_hi++;
    for (int i = 10; i < 128; i++) if (x[i] !== 8'd0) bad_lo++;
    tests++; if (bad_hi != 0) begin failed++; $display("FAIL short_x_head: got %0d wrong entries expected 0", bad_hi); end
    tests++; if (bad_lo != 0) begin failed++; $display("FAIL short_x_tail: got %0d nonzero entries expected 0", bad_lo); end
  endtask

  task automatic test_long();
    int lc, lc2, e0;
    for (int i = 0; i < 130; i++) vec[i] = 8'(i+1);
    m_ready = 1'b1;
    clear_results();
    e0 = err_cnt;
    stream(0, 128, 1'b0, lc);
    stream(128, 2, 1'b0, lc2);
    wait_results(1);
    tests++; if (err_cnt - e0 != 1) begin failed++; $display("FAIL long_err_count: got %0d expected 1", err_cnt - e0); end
    tests++; if (err_cyc - lc != 1) begin failed++; $display("FAIL long_err_timing: got %0d expected 1 (negedges after beat 128)", err_cyc - lc); end
    tests++; if (res_q.size() != 1) begin failed++; $display("FAIL long_count: got %0d expected 1", res_q.size()); end
    if (res_q.size() >= 1) begin
      tests++; if (res_q[0] !== 23'd8256) begin failed++; $display("FAIL long_data: got %0d expected 8256", res_q[0]); end
    end
    tests++; if (x[0] !== 8'd129 || x[1] !== 8'd130) begin failed++; $display("FAIL long_next_vector: got x0=%0d x1=%0d expected 129 130", x[0], x[1]); end
  endtask

  task automatic test_reset_mid();
    int lc, e0;
    for (int i = 0; i < 128; i++) vec[i] = 8'd2;
    m_ready = 1'b1;
    stream(0, 60, 1'b0, lc);
    #2 rst = 1'b1;
    #1;
    tests++; if (s_ready !== 1'b1 || m_valid !== 1'b0) begin failed++; $display("FAIL rst60_flags: got s_ready=%0b m_valid=%0b expected 1 0", s_ready, m_valid); end
    tests++; if (x[5] !== 8'd0) begin failed++; $display("FAIL rst60_x: got %0d expected 0", x[5]); end
    @(posedge clk); #1;
    rst = 1'b0;
    clear_results();
    e0 = err_cnt;
    stream(0, 128, 1'b1, lc);
    wait_results(1);
    tests++; if (res_q.size() != 1) begin failed++; $display("FAIL rst60_count: got %0d expected 1", res_q.size()); end
    if (res_q.size() >= 1) begin
      tests++; if (res_q[0] !== 23'd256) begin failed++; $display("FAIL rst60_data: got %0d expected 256", res_q[0]); end
    end
    tests++; if (err_cnt != e0) begin failed++; $display("FAIL rst60_err_len: got %0d pulses expected 0", err_cnt - e0); end

    for (int i = 0; i < 128; i++) vec[i] = 8'd1;
    m_ready = 1'b0;
    clear_results();
    stream(0, 128, 1'b1, lc);
    wait_valid();
    tests++; if (m_valid !== 1'b1) begin failed++; $display("FAIL rstout_valid_rise: got %0b expected 1", m_valid); end
    #2 rst = 1'b1;
    #1;
    tests++; if (m_valid !== 1'b0) begin failed++; $display("FAIL rstout_valid: got %0b expected 0", m_valid); end
    tests++; if (m_data !== 23'd0) begin failed++; $display("FAIL rstout_m_data: got %0d expected 0", m_data); end
    @(posedge clk); #1;
    rst = 1'b0;
    m_ready = 1'b1;
    for (int i = 0; i < 128; i++) vec[i] = 8'(i+1);
    stream(0, 128, 1'b1, lc);
    wait_results(1);
    repeat (2) @(posedge clk);
    #1;
    tests++; if (res_q.size() != 1) begin failed++; $display("FAIL rstout_count: got %0d expected 1", res_q.size()); end
    if (res_q.size() >= 1) begin
      tests++; if (res_q[0] !== 23'd8256) begin failed++; $display("FAIL rstout_data: got %0d expected 8256", res_q[0]); end
    end
  endtask

`ifdef FC_DRIVER_DOUBLE_BUFFER_EN
  task automatic test_double_buffer();
    int lc;
    m_ready = 1'b1;
    clear_results();
    for (int v = 1; v <= 3; v++) begin
      for (int i = 0; i < 128; i++) vec[i] = 8'(v);
      stream(0, 128, 1'b1, lc);
    end
    wait_results(3);
    tests++; if (res_q.size() != 3) begin failed++; $display("FAIL db_count: got %0d expected 3", res_q.size()); end
    if (res_q.size() == 3) begin
      tests++; if (res_q[0] !== 23'd128 || res_q[1] !== 23'd256 || res_q[2] !== 23'd384) begin
        failed++; $display("FAIL db_data: got %0d %0d %0d expected 128 256 384", res_q[0], res_q[1], res_q[2]);
      end
      tests++; if (res_cyc[1] - res_cyc[0] != 128 || res_cyc[2] - res_cyc[1] != 128) begin
        failed++; $display("FAIL db_spacing: got %0d %0d expected 128 128", res_cyc[1] - res_cyc[0], res_cyc[2] - res_cyc[1]);
      end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_base();
`ifdef FC_DRIVER_DOUBLE_BUFFER_EN
    test_short();
    test_double_buffer();
`else
    test_backpressure();
    test_short();
    test_long();
    test_reset_mid();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, finished=0 required 1");
    $fatal(1, "watchdog");
  end

endmodule
